lisnoc_vc_link_arbiter: RTL
===========================

// Module: lisnoc_vc_link_arbiter
// PURPOSE
//  Shares one physical mesh link (flit bus + per-VC valid/ready) among vchannels virtual-channel sources.
//  Sits between the per-VC output queues of a router/NI port and a mesh link input.
//  Round-robin per flit; output is registered (1 flit buffer, tagged with its VC).
// PARAMETERS
//  vchannels   1            number of virtual channels sharing the link (1..8)
//  flit_width  `FLIT_WIDTH  flit bus width; flit[flit_width-1 -: 2] is the flit type
// PORTS
//  clk         in   1                     clock
//  rst         in   1                     reset; asynchronous, active-low
//  in_flit_i   in   vchannels*flit_width  per-VC source flits; VC v at [v*flit_width +: flit_width]
//  in_valid_i  in   vchannels             per-VC source valid
//  in_ready_o  out  vchannels             per-VC accept; at most one bit high (the grant)
//  out_flit_o  out  flit_width            registered link flit
//  out_valid_o out  vchannels             registered link valid; one-hot or zero
//  out_ready_i in   vchannels             per-VC link ready from downstream
// BEHAVIOUR
//  - Reset (rst=0, async): out_valid_o=0, out_flit_o=0, rr pointer=0, lock=none; in_ready_o=0 while rst=0.
//  - Output register: full while out_valid_o!=0. It holds one flit and its VC index obuf_vc.
//  - Consume: (out_valid_o & out_ready_i) != 0 in cycle c. The register empties at edge c+1 unless it is reloaded.
//  - load_en = !full | consume. The same-cycle drain+reload gives full throughput of 1 flit/cycle.
//  - Grant: when load_en, choose the first v with in_valid_i[v]. Search order is ptr, ptr+1, ..., wrapping mod vchannels.
//    in_ready_o[v]=1 for the winner only. The handshake completes when in_valid_i[v]&in_ready_o[v].
//  - At edge: out_flit_o <= in_flit[v]; out_valid_o <= 1<<v; ptr <= (v+1)%vchannels.
//    With no grant, ptr is unchanged and out_valid_o clears if the flit was consumed.
//  - Latency: flit accepted in cycle c appears on the link in cycle c+1.
//  - in_ready_o is combinational from in_valid_i and out_ready_i. Sources must not make valid depend on ready.
//  - Head-of-line: while the register holds VC v and out_ready_i[v]=0, no VC is granted.
//  - Flit content is never inspected (without the macro); out_flit_o holds its value while out_valid_o=0.
//  - vchannels=1: ptr is constant 0; the block degenerates to a 1-deep pipeline register.
//  - Reset mid-packet: the in-flight flit is discarded. Upstream and downstream reset together; no recovery is needed.
// CONFIGURATION
//  LISNOC_VC_ARB_PKT_LOCK_EN
//  - Defined: wormhole lock.
//    - A granted HEADER flit locks the link to that VC.
//    - Only that VC may be granted until its LAST flit is accepted, then lock=none.
//    - SINGLE and PAYLOAD flits never set the lock.
//    - ptr still advances only on grants.
//    - A locked VC with in_valid_i=0 stalls the link; no other VC is granted.
//  - Undefined: free per-flit interleaving as above; no lock state is synthesised.
// STRUCTURE
//  - Package lisnoc_arb_pkg holds:
//    - flit_type_t enum: HEADER=2'b01, PAYLOAD=2'b00, LAST=2'b10, SINGLE=2'b11.
//    - localparam TYPE_MSB.
//    - function clog2_min1(n) for ptr/VC index widths (min 1 bit).
//  - Sub-module lisnoc_rr_arbiter #(n):
//    - Ports: req[n], ptr, gnt[n] one-hot, gnt_idx.
//    - Purely combinational; reused by router switch allocators.
//  - Top-level holds the output register, obuf_vc, ptr and the optional lock FSM (IDLE/LOCKED, locked_vc).
// TESTING (vchannels=2, flit_width=34, macro undefined unless stated)
//  1. Reset: assert rst=0 mid-traffic.
//     -> out_valid_o=2'b00 and in_ready_o=2'b00 immediately, without waiting for clk.
//     -> After release, the first grant goes to VC0 when both VCs are valid.
//  2. Both valid continuously, out_ready_i=2'b11.
//     -> Grants alternate VC0,VC1,VC0...
//     -> out_valid_o alternates 01,10 every cycle, with 1 flit/cycle throughput.
//  3. Flit 0x1_2345_6789 on VC1 only, out_ready_i=2'b11.
//     -> Accepted in cycle c.
//     -> In cycle c+1: out_flit_o=0x1_2345_6789 and out_valid_o=2'b10; the register is empty in c+2.
//  4. Register holds VC0 with out_ready_i=2'b10, and VC1 is valid.
//     -> in_ready_o=0 until out_ready_i[0]=1.
//     -> That cycle VC1 is granted; the same-cycle drain+reload is checked.
//  5. PKT_LOCK_EN defined: VC0 sends HEADER,PAYLOAD,LAST while VC1 stays valid.
//     -> VC1 gets no grant until the cycle after LAST is accepted.
//     -> Repeat with VC0 invalid for 3 cycles mid-packet -> the link idles and VC1 stays blocked.
//  6. Random valid/ready, 10k cycles, scoreboard per VC.
//     -> In-order, lossless, no duplicate flits.
//     -> in_ready_o and out_valid_o are always one-hot or zero.

Source files
------------

// File: rtl/lisnoc_vc_link_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// lisnoc_arb_pkg
// Shared types and helpers for the virtual-channel link arbiter and the
// round-robin arbiter that router switch allocators reuse.
//   flit_type_t  - 2-bit flit type carried in the top bits of every flit
//   TYPE_MSB     - bit index of the type field's MSB at the default flit width
//   clog2_min1   - index width for n entries, never narrower than 1 bit
// ---------------------------------------------------------------------------
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 34
`endif

package lisnoc_arb_pkg;

  typedef enum logic [1:0] {
    PAYLOAD = 2'b00,
    HEADER  = 2'b01,
    LAST    = 2'b10,
    SINGLE  = 2'b11
  } flit_type_t;

  // The type field is flit[TYPE_MSB -: 2].
  localparam int TYPE_MSB = `FLIT_WIDTH - 1;

  // A single VC still needs a 1-bit pointer/index so ports stay legal.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lisnoc_vc_link_arbiter_if.sv
// ---------------------------------------------------------------------------
// lisnoc_vc_link_arbiter_if
// Bundles the per-VC source side and the shared link side of the arbiter.
//   in_flit_i   vchannels*flit_width  per-VC flits, VC v at [v*flit_width +: flit_width]
//   in_valid_i  vchannels             per-VC source valid
//   in_ready_o  vchannels             per-VC grant/accept (at most one bit high)
//   out_flit_o  flit_width            registered link flit
//   out_valid_o vchannels             registered link valid, one-hot or zero
//   out_ready_i vchannels             per-VC ready from downstream
// Modports: slave = the arbiter, master = the surrounding queues and link.
// ---------------------------------------------------------------------------
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 34
`endif

interface lisnoc_vc_link_arbiter_if #(
  parameter int vchannels  = 1,
  parameter int flit_width = `FLIT_WIDTH
);
  logic [vchannels*flit_width-1:0] in_flit_i;
  logic [vchannels-1:0]            in_valid_i;
  logic [vchannels-1:0]            in_ready_o;
  logic [flit_width-1:0]           out_flit_o;
  logic [vchannels-1:0]            out_valid_o;
  logic [vchannels-1:0]            out_ready_i;

  modport slave (
    input  in_flit_i, in_valid_i, out_ready_i,
    output in_ready_o, out_flit_o, out_valid_o
  );

  modport master (
    output in_flit_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_flit_o, out_valid_o
  );
endinterface

// File: rtl/lisnoc_vc_link_arbiter_rr.sv
// ---------------------------------------------------------------------------
// lisnoc_rr_arbiter
// Purely combinational round-robin pick: the first set bit of req searching
// ptr, ptr+1, ... wrapping mod n.
//   req      n   request vector
//   ptr      W   highest-priority index this cycle (must be < n)
//   gnt      n   one-hot grant, zero when no request
//   gnt_idx  W   index of the granted bit (0 when no request)
// ---------------------------------------------------------------------------
module lisnoc_rr_arbiter
  import lisnoc_arb_pkg::*;
#(
  parameter  int n = 2,
  localparam int W = clog2_min1(n)
) (
  input  logic [n-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [n-1:0] gnt,
  output logic [W-1:0] gnt_idx
);

  always_comb begin : search
    logic         found;
    logic [W-1:0] k;
    // NOTE: every variable gets a default before the loop, so no path through
    // this block leaves a value held and no latch is inferred.
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = '0;
    for (int i = 0; i < n; i++) begin
      k = W'((int'(ptr) + i) % n);
      if (!found && req[k]) begin
        found   = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = k;
      end
    end
  end

endmodule

// File: rtl/lisnoc_vc_link_arbiter.sv
// ---------------------------------------------------------------------------
// lisnoc_vc_link_arbiter
// Shares one mesh link among vchannels virtual-channel sources. One flit is
// granted per cycle round-robin and held in a single output register tagged
// with its VC; a flit accepted in cycle c is on the link in cycle c+1, and a
// same-cycle drain+reload sustains 1 flit/cycle.
//   clk   clock
//   rst   asynchronous, active-low reset
//   link  lisnoc_vc_link_arbiter_if.slave (source flits/valid/ready, link
//         flit/valid/ready)
// Build option: LISNOC_VC_ARB_PKT_LOCK_EN adds a wormhole lock - a granted
// HEADER locks the link to its VC until that VC's LAST flit is accepted.
// ---------------------------------------------------------------------------
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 34
`endif

module lisnoc_vc_link_arbiter
  import lisnoc_arb_pkg::*;
#(
  parameter int vchannels  = 1,
  parameter int flit_width = `FLIT_WIDTH
) (
  input logic                     clk,
  input logic                     rst,
  lisnoc_vc_link_arbiter_if.slave link
);

  localparam int PW = clog2_min1(vchannels);

  logic [flit_width-1:0] r_out_flit;
  logic [vchannels-1:0]  r_out_valid;
  logic [PW-1:0]         r_obuf_vc;
  logic [PW-1:0]         r_ptr;

  logic                  w_full;
  logic                  w_consume;
  logic                  w_load_en;
  logic                  w_any_gnt;
  logic [vchannels-1:0]  w_lock_mask;
  logic [vchannels-1:0]  w_req;
  logic [vchannels-1:0]  w_gnt;
  logic [PW-1:0]         w_gnt_idx;
  logic [PW-1:0]         w_ptr_nxt;
  logic [flit_width-1:0] w_sel_flit;

  assign w_full    = |r_out_valid;
  // Only the buffered VC's ready matters; a stalled VC blocks the whole link.
  assign w_consume = w_full & link.out_ready_i[r_obuf_vc];
  assign w_load_en = ~w_full | w_consume;

  // Requests are masked while the register cannot load and while in reset,
  // which keeps in_ready_o low asynchronously during reset.
  assign w_req = link.in_valid_i & w_lock_mask & {vchannels{w_load_en & rst}};

  lisnoc_rr_arbiter #(.n(vchannels)) u_rr (
    .req     (w_req),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign w_any_gnt  = |w_gnt;
  assign w_sel_flit = link.in_flit_i[w_gnt_idx*flit_width +: flit_width];
  assign w_ptr_nxt  = (w_gnt_idx == PW'(vchannels - 1)) ? '0 : w_gnt_idx + 1'b1;

  assign link.in_ready_o  = w_gnt;
  assign link.out_flit_o  = r_out_flit;
  assign link.out_valid_o = r_out_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the flit register is reset as well even though valid qualifies
      // it, so the link shows a defined all-zero flit out of reset.
      r_out_flit  <= '0;
      r_out_valid <= '0;
      r_obuf_vc   <= '0;
      r_ptr       <= '0;
    end else if (w_load_en) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      if (w_any_gnt) begin
        r_out_flit  <= w_sel_flit;
        r_out_valid <= w_gnt;
        r_obuf_vc   <= w_gnt_idx;
        r_ptr       <= w_ptr_nxt;
      end else begin
        r_out_valid <= '0;
      end
    end
  end

`ifdef LISNOC_VC_ARB_PKT_LOCK_EN
  typedef enum logic {IDLE, LOCKED} lock_state_t;

  lock_state_t r_lock_state, w_lock_state_nxt;
  logic [PW-1:0] r_locked_vc, w_locked_vc_nxt;
  flit_type_t    w_sel_type;

  assign w_sel_type  = flit_type_t'(w_sel_flit[flit_width-1 -: 2]);
  assign w_lock_mask = (r_lock_state == LOCKED) ? (vchannels'(1) << r_locked_vc) : '1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lock_state <= IDLE;
      r_locked_vc  <= '0;
    end else begin
      r_lock_state <= w_lock_state_nxt;
      r_locked_vc  <= w_locked_vc_nxt;
    end
  end

  // A grant here is always a completed handshake, so the flit type of the
  // selected flit is the type of the flit being accepted.
  always_comb begin
    w_lock_state_nxt = r_lock_state;
    w_locked_vc_nxt  = r_locked_vc;
    case (r_lock_state)
      IDLE: begin
        if (w_any_gnt && w_sel_type == HEADER) begin
          w_lock_state_nxt = LOCKED;
          w_locked_vc_nxt  = w_gnt_idx;
        end
      end
      LOCKED: begin
        if (w_any_gnt && w_sel_type == LAST) w_lock_state_nxt = IDLE;
      end
      default: w_lock_state_nxt = IDLE;
    endcase
  end
`else
  assign w_lock_mask = '1;
`endif

endmodule
